// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill controller.
// On a fetch miss it requests the missing line from memory. It streams the
// returned beats into the data array and then installs the tag. A fetch
// redirect during the refill still lets the line be installed, but the
// redirect suppresses the completion pulse to the fetch stage.
module icache_refill_ctrl #(
    parameter int CACHE_WIDTHE = 5,   // log2 of line size in bytes
    parameter int CACHE_DEEPTHE = 6   // log2 of line count
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic                                     iMissVld,
    input  logic [31:0]                              iMissPc,
    input  logic                                     iFlush,
    output logic                                     oMemReq,
    output logic [31:0]                              oMemAddr,
    input  logic                                     iMemGnt,
    input  logic                                     iMemRdVld,
    input  logic [31:0]                              iMemRdData,
    output logic                                     oWordWe,
    output logic [CACHE_DEEPTHE-1:0]                 oLineIdx,
    output logic [CACHE_WIDTHE-3:0]                  oWordOff,
    output logic [31:0]                              oWordData,
    output logic                                     oTagWe,
    output logic [31-CACHE_WIDTHE-CACHE_DEEPTHE:0]   oTag,
    output logic                                     oValid,
    output logic                                     oFeStall,
    output logic                                     oRefillDone
);

    localparam int OFF_W  = CACHE_WIDTHE - 2;
    localparam int TAG_W  = 32 - CACHE_WIDTHE - CACHE_DEEPTHE;
    localparam int LINE_W = 32 - CACHE_WIDTHE;
    localparam logic [OFF_W-1:0] LAST_OFF = {OFF_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [LINE_W-1:0]   miss_line_q, miss_line_d;  // miss PC without byte-in-line bits
    logic [OFF_W-1:0]    cnt_q, cnt_d;
    logic                flushed_q, flushed_d;

    // The byte offset inside the line never reaches any output.
    logic unused_pc_bits;
    assign unused_pc_bits = ^iMissPc[CACHE_WIDTHE-1:0];

    // Line-derived fields are pure functions of the latched miss address.
    assign oMemAddr = {miss_line_q, {CACHE_WIDTHE{1'b0}}};
    assign oLineIdx = miss_line_q[CACHE_DEEPTHE-1:0];
    assign oTag     = miss_line_q[LINE_W-1 -: TAG_W];
    assign oWordOff = cnt_q;

    // State register plus the refill context (address, beat counter, redirect flag).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            miss_line_q <= '0;
            cnt_q       <= '0;
            flushed_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            miss_line_q <= miss_line_d;
            cnt_q       <= cnt_d;
            flushed_q   <= flushed_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no latch is inferred.
        state_d     = state_q;
        miss_line_d = miss_line_q;
        cnt_d       = cnt_q;
        flushed_d   = flushed_q;
        oMemReq     = 1'b0;
        oWordWe     = 1'b0;
        oWordData   = '0;
        oTagWe      = 1'b0;
        oValid      = 1'b0;
        oRefillDone = 1'b0;
        oFeStall    = 1'b1;

        unique case (state_q)
            IDLE: begin
                oFeStall = iMissVld;
                if (iMissVld) begin
                    miss_line_d = iMissPc[31:CACHE_WIDTHE];
                    flushed_d   = 1'b0;
                    state_d     = REQ;
                end
            end

            REQ: begin
                oMemReq = 1'b1;
                if (iMemGnt) begin
                    // Invalidate the victim line as soon as memory commits to the burst.
                    oTagWe  = 1'b1;
                    oValid  = 1'b0;
                    cnt_d   = '0;
                    state_d = FILL;
                    if (iFlush) begin
                        flushed_d = 1'b1;
                    end
                end else if (iFlush) begin
                    state_d = IDLE;
                end
            end

            FILL: begin
                if (iFlush) begin
                    flushed_d = 1'b1;
                end
                if (iMemRdVld) begin
                    oWordWe   = 1'b1;
                    oWordData = iMemRdData;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_OFF) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                oTagWe      = 1'b1;
                oValid      = 1'b1;
                oRefillDone = ~(flushed_q | iFlush);
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 The block SHALL have parameter CACHE_WIDTHE, default 5, meaning log2 of line size in bytes; WORDS = 2^(CACHE_WIDTHE-2) = 8.
REQ-002 The block SHALL have parameter CACHE_DEEPTHE, default 6, meaning log2 of line count; TAG_W = 32-CACHE_WIDTHE-CACHE_DEEPTHE.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 iMissVld  in  1  fetch lookup missed this cycle.
REQ-006 iMissPc  in  32  PC of the missing fetch.
REQ-007 iFlush  in  1  fetch redirect (branch/jump), one-cycle pulse.
REQ-008 oMemReq  out  1  line read request to memory.
REQ-009 oMemAddr  out  32  line-aligned read address.
REQ-010 iMemGnt  in  1  memory accepted request.
REQ-011 iMemRdVld / iMemRdData  in  1 / 32  read beat valid / data.
REQ-012 oWordWe / oLineIdx / oWordOff / oWordData  out  1 / CACHE_DEEPTHE / CACHE_WIDTHE-2 / 32  data-array word write.
REQ-013 oTagWe / oTag / oValid  out  1 / TAG_W / 1  tag+valid array write.
REQ-014 oFeStall  out  1  hold PC generator.
REQ-015 oRefillDone  out  1  one-cycle pulse: line installed for live fetch.

Function
REQ-016 FSM states SHALL be IDLE, REQ, FILL, DONE.
REQ-017 IDLE: iMissVld=1 SHALL latch iMissPc into missPc and go to REQ next cycle; flushed flag cleared.
REQ-018 iMissVld SHALL be ignored in every state except IDLE.
REQ-019 oLineIdx SHALL be missPc[CACHE_WIDTHE +: CACHE_DEEPTHE]; oTag SHALL be missPc[31 -: TAG_W]; oMemAddr SHALL be missPc with low CACHE_WIDTHE bits zeroed.
REQ-020 REQ: oMemReq=1, oMemAddr stable until grant; iMemGnt=1 SHALL move to FILL, clear beat counter, and in that same cycle assert oTagWe=1, oValid=0 (invalidate line).
REQ-021 REQ with iFlush=1 and iMemGnt=0 SHALL drop the request and return to IDLE; iFlush and iMemGnt both 1 SHALL take the grant and set flushed.
REQ-022 FILL: each cycle with iMemRdVld=1 SHALL assert oWordWe=1, oWordOff=counter, oWordData=iMemRdData, and increment counter (width CACHE_WIDTHE-2, wraps to 0).
REQ-023 FILL: cycles with iMemRdVld=0 SHALL write nothing; gaps of any length allowed.
REQ-024 FILL: beat with counter=WORDS-1 SHALL move to DONE.
REQ-025 iMemRdVld outside FILL SHALL be ignored.
REQ-026 iFlush in FILL or DONE SHALL set flushed; burst SHALL still complete and line SHALL still be installed (data correct for missPc).
REQ-027 DONE (one cycle): oTagWe=1, oValid=1, oTag per REQ-019; oRefillDone = ~flushed (including iFlush in this cycle); next state IDLE.
REQ-028 oFeStall SHALL equal iMissVld when in IDLE, and 1 in REQ, FILL, DONE.
REQ-029 Minimum miss-to-DONE latency: 1 (IDLE->REQ) + 1 (grant) + WORDS beats = 10 cycles with immediate grant and back-to-back beats.
REQ-030 oMemReq, oWordWe, oTagWe, oRefillDone SHALL never be asserted in IDLE.

Reset
REQ-031 rstn=0 SHALL asynchronously force state IDLE, counter 0, missPc 0, flushed 0.
REQ-032 During reset all outputs SHALL be 0 except oFeStall, which follows iMissVld per REQ-028.
REQ-033 Reset mid-REQ/FILL SHALL abandon the refill without issuing tag write; line state is left as previously written (invalidated if grant occurred).

Verification
REQ-034 Miss iMissPc=0x0000_0204, immediate gnt, 8 back-to-back beats D0..D7 -> oMemAddr=0x0000_0200, invalidate write idx 16, oWordOff 0..7 with D0..D7 at idx 16, DONE: oTag=0, oValid=1, oRefillDone=1, oFeStall low the cycle after DONE.
REQ-035 Miss 0xFFFF_FFE0, iMemGnt delayed 3 cycles -> oMemReq high 4 cycles, address 0xFFFF_FFE0 stable, idx 63, tag 0x1FFFFF, refill completes normally.
REQ-036 iFlush in REQ before grant -> oMemReq drops next cycle, IDLE, no tag/word writes, no oRefillDone.
REQ-037 iFlush after beat 3 in FILL -> remaining 4 beats written, DONE tag write oValid=1, oRefillDone=0.
REQ-038 Beats with iMemRdVld gaps (1,0,0,1,...) plus spurious iMemRdVld in REQ/IDLE and iMissVld during FILL -> exactly 8 writes, offsets 0..7, second miss ignored.
REQ-039 rstn asserted after beat 5 -> all outputs 0 immediately, IDLE after release, no oTagWe with oValid=1; new miss then refills correctly.
